// File: rtl/ssd_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
//   SEG_TABLE : hex nibble -> active-high segments {g,f,e,d,c,b,a}, a = bit 0
//   SEG_OFF   : all segments off (active-high)
//   idx_width : width of a digit index able to address n digits
package ssd_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-high segments {g,f,e,d,c,b,a}
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/multi_ssd_driver.sv
// Time-multiplexed driver for NUM_DIGITS seven-segment digits with
// shadowed data, leading-zero blanking and PWM brightness.
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   En          : display enable (counters held at 0 and outputs dark when low)
//   Load        : strobe capturing DataIn / DP_In into the shadow registers
//   DataIn      : one hex nibble per digit, digit 0 rightmost
//   DP_In       : decimal point per digit
//   Blank_LZ    : leading-zero blanking enable
//   Brightness  : PWM on-time (all ones = always on, 0 = dark)
//   SSD_Out     : registered {DP,g..a}, polarity per COMMON_ANODE
//   SSD_Select  : registered one-hot digit select, polarity per COMMON_ANODE
//   Frame_Done  : one-cycle pulse when the digit index wraps
module multi_ssd_driver
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV_COUNT    = 50000,
  parameter int unsigned COMMON_ANODE = 1,
  parameter int unsigned PWM_BITS     = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    En,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] DataIn,
  input  logic [NUM_DIGITS-1:0]   DP_In,
  input  logic                    Blank_LZ,
  input  logic [PWM_BITS-1:0]     Brightness,
  output logic [7:0]              SSD_Out,
  output logic [NUM_DIGITS-1:0]   SSD_Select,
  output logic                    Frame_Done
);

  localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
  localparam int unsigned DIV_W = $clog2(DIV_COUNT);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Dark level of each output; XOR with it converts active-high to pin polarity.
  localparam logic [7:0]            OUT_DARK = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_DARK = (COMMON_ANODE != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [PWM_BITS-1:0]     pwm_cnt;

  logic                    tick;
  logic                    wrap;
  logic                    lit;
  logic [3:0]              sel_nibble;
  logic                    sel_dp;
  logic                    sel_blank;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    upper_zero;
  logic [6:0]              seg;

  assign tick = En && (div_cnt == DIV_LAST);
  assign wrap = tick && (idx == IDX_LAST);
  assign lit  = En && ((Brightness == '1) || (pwm_cnt < Brightness));

  // Digit i is a leading zero when nibbles i..NUM_DIGITS-1 are all zero;
  // digit 0 is never blanked so a value of zero still shows "0".
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (shadow_data[4*i +: 4] == 4'h0);
      lz_blank[i] = Blank_LZ && upper_zero;
    end
  end

  always_comb begin
    sel_nibble = '0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    onehot     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_nibble = shadow_data[4*i +: 4];
        sel_dp     = shadow_dp[i];
        sel_blank  = lz_blank[i];
        onehot[i]  = 1'b1;
      end
    end
  end

  ssd_hex_decoder u_decoder (
    .nibble (sel_nibble),
    .seg    (seg)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else if (Load) begin
      shadow_data <= DataIn;
      shadow_dp   <= DP_In;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      Frame_Done <= 1'b0;
    end else if (!En) begin
      div_cnt    <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      Frame_Done <= 1'b0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      pwm_cnt    <= pwm_cnt + 1'b1;
      Frame_Done <= wrap;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      SSD_Out    <= OUT_DARK;
      SSD_Select <= SEL_DARK;
    end else if (lit) begin
      SSD_Out    <= {sel_dp, (sel_blank ? SEG_OFF : seg)} ^ OUT_DARK;
      SSD_Select <= onehot ^ SEL_DARK;
    end else begin
      SSD_Out    <= OUT_DARK;
      SSD_Select <= SEL_DARK;
    end
  end

endmodule

// File: tb/tb_multi_ssd_driver.sv
// Self-checking bench for multi_ssd_driver: a common-cathode instance (a)
// checked through an event scoreboard, and a common-anode instance (b)
// sharing the same stimulus for polarity and reset behaviour.
module tb_multi_ssd_driver;

  logic        clk = 1'b0;
  logic        rst_n, en, load, blank_lz;
  logic [15:0] data_in;
  logic [3:0]  dp_in, brightness;
  logic [7:0]  out_a, out_b;
  logic [3:0]  sel_a, sel_b;
  logic        fd_a, fd_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] out;
    logic [3:0] sel;
  } disp_t;

  disp_t exp_q[$];
  bit    mon_en = 1'b0;
  disp_t prev;

  always #5 clk = ~clk;

  multi_ssd_driver #(
    .NUM_DIGITS   (4),
    .DIV_COUNT    (4),
    .COMMON_ANODE (0),
    .PWM_BITS     (4)
  ) dut_a (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .En         (en),
    .Load       (load),
    .DataIn     (data_in),
    .DP_In      (dp_in),
    .Blank_LZ   (blank_lz),
    .Brightness (brightness),
    .SSD_Out    (out_a),
    .SSD_Select (sel_a),
    .Frame_Done (fd_a)
  );

  multi_ssd_driver #(
    .NUM_DIGITS   (4),
    .DIV_COUNT    (4),
    .COMMON_ANODE (1),
    .PWM_BITS     (4)
  ) dut_b (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .En         (en),
    .Load       (load),
    .DataIn     (data_in),
    .DP_In      (dp_in),
    .Blank_LZ   (blank_lz),
    .Brightness (brightness),
    .SSD_Out    (out_b),
    .SSD_Select (sel_b),
    .Frame_Done (fd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_data(input logic [15:0] d, input logic [3:0] dp);
    data_in = d;
    dp_in   = dp;
    load    = 1'b1;
    step(1);
    load    = 1'b0;
  endtask

  task automatic expect_disp(input logic [7:0] o, input logic [3:0] s);
    disp_t e;
    e.out = o;
    e.sel = s;
    exp_q.push_back(e);
  endtask

  // Monitor: every change of instance a's display pins is one presented
  // output and consumes the next scoreboard entry.
  always @(negedge clk) begin
    disp_t cur;
    disp_t e;
    cur.out = out_a;
    cur.sel = sel_a;
    if (mon_en && (cur !== prev)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got out=%h sel=%b with nothing expected at %0t",
                 cur.out, cur.sel, $time);
      end else begin
        e = exp_q.pop_front();
        check("display_event", 32'(cur), 32'(e));
      end
    end
    prev = cur;
  end

  initial begin
    int fd_cnt;
    int lit_cnt;
    int dark_bad;

    rst_n      = 1'b1;
    en         = 1'b0;
    load       = 1'b0;
    blank_lz   = 1'b0;
    data_in    = '0;
    dp_in      = '0;
    brightness = 4'hF;
    #1 rst_n = 1'b0;
    #2;
    check("reset_out_a", out_a, 8'h00);
    check("reset_sel_a", sel_a, 4'h0);
    check("reset_fd_a",  fd_a,  1'b0);
    check("reset_out_b", out_b, 8'hFF);
    check("reset_sel_b", sel_b, 4'hF);
    check("reset_fd_b",  fd_b,  1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(3);
    check("idle_sel_a", sel_a, 4'h0);
    check("idle_out_b", out_b, 8'hFF);

    // Scan: 0x12AB shows B,A,2,1 on digits 0..3, four cycles each.
    load_data(16'h12AB, 4'b0000);
    for (int f = 0; f < 2; f++) begin
      expect_disp(8'h7C, 4'b0001);
      expect_disp(8'h77, 4'b0010);
      expect_disp(8'h5B, 4'b0100);
      expect_disp(8'h06, 4'b1000);
    end
    expect_disp(8'h00, 4'b0000);
    en     = 1'b1;
    mon_en = 1'b1;
    fd_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      step(1);
      if (fd_a) fd_cnt++;
    end
    check("scan_frame_done_count", fd_cnt, 2);
    en = 1'b0;
    step(2);
    check("scan_drained", exp_q.size(), 0);

    // Leading-zero blanking with a decimal point on a blanked digit.
    blank_lz = 1'b1;
    load_data(16'h0005, 4'b0100);
    expect_disp(8'h6D, 4'b0001);
    expect_disp(8'h00, 4'b0010);
    expect_disp(8'h80, 4'b0100);
    expect_disp(8'h00, 4'b1000);
    expect_disp(8'h00, 4'b0000);
    en = 1'b1;
    step(16);
    en = 1'b0;
    step(2);
    check("blank_drained", exp_q.size(), 0);

    // Shadow: unloaded DataIn changes are invisible until the next Load.
    blank_lz = 1'b0;
    load_data(16'h1111, 4'b0000);
    expect_disp(8'h06, 4'b0001);
    expect_disp(8'h06, 4'b0010);
    expect_disp(8'h06, 4'b0100);
    expect_disp(8'h06, 4'b1000);
    expect_disp(8'h00, 4'b0000);
    en      = 1'b1;
    data_in = 16'h2222;
    step(16);
    en = 1'b0;
    step(2);
    load_data(16'h2222, 4'b0000);
    expect_disp(8'h5B, 4'b0001);
    expect_disp(8'h00, 4'b0000);
    en = 1'b1;
    step(4);
    en = 1'b0;
    step(2);
    check("shadow_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // PWM duty: Brightness=4 lights 4 of 16 cycles; Brightness=0 stays dark.
    load_data(16'h12AB, 4'b0000);
    brightness = 4'h4;
    en         = 1'b1;
    lit_cnt    = 0;
    for (int c = 0; c < 32; c++) begin
      step(1);
      if (sel_a != 4'h0) lit_cnt++;
    end
    check("pwm_b4_lit_cycles", lit_cnt, 8);
    brightness = 4'h0;
    step(1);
    lit_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      step(1);
      if (sel_a != 4'h0) lit_cnt++;
    end
    check("pwm_b0_lit_cycles", lit_cnt, 0);
    en = 1'b0;
    step(2);
    brightness = 4'hF;

    // Mid-slot asynchronous reset; shadow clears so every digit shows 0.
    load_data(16'h12AB, 4'b0000);
    en = 1'b1;
    step(6);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_b", out_b, 8'hFF);
    check("midreset_sel_b", sel_b, 4'hF);
    check("midreset_fd_b",  fd_b,  1'b0);
    check("midreset_sel_a", sel_a, 4'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1);
      check("post_reset_sel_b", sel_b, (c < 4) ? 4'b1110 : 4'b1101);
      check("post_reset_out_b", out_b, 8'hC0);
    end

    // Disabled: dark outputs and no Frame_Done.
    en       = 1'b0;
    fd_cnt   = 0;
    dark_bad = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (fd_a || fd_b) fd_cnt++;
      if (sel_b != 4'hF || out_b != 8'hFF || sel_a != 4'h0) dark_bad++;
    end
    check("disabled_frame_done", fd_cnt, 0);
    check("disabled_dark_cycles_bad", dark_bad, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_ssd_driver.md
MULTI_SSD_DRIVER -- requirements
Module: multi_ssd_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter DIV_COUNT, default 50000, meaning Clk cycles per digit slot (legal >= 2).
REQ-003 The block SHALL have parameter COMMON_ANODE, default 1, meaning 1 inverts SSD_Out and SSD_Select (active-low) and 0 drives them active-high.
REQ-004 The block SHALL have parameter PWM_BITS, default 4, meaning the brightness resolution.
REQ-005 Clk  in  1  sole clock; all state SHALL change on posedge Clk.
REQ-006 Rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 En  in  1  display enable.
REQ-008 Load  in  1  single-cycle strobe that captures DataIn and DP_In.
REQ-009 DataIn  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, where digit 0 is rightmost.
REQ-010 DP_In  in  NUM_DIGITS  decimal point per digit.
REQ-011 Blank_LZ  in  1  leading-zero blanking enable.
REQ-012 Brightness  in  PWM_BITS  on-time duty.
REQ-013 SSD_Out  out  8  {DP, g,f,e,d,c,b,a} after polarity.
REQ-014 SSD_Select  out  NUM_DIGITS  one-hot digit select after polarity.
REQ-015 Frame_Done  out  1  one-cycle pulse at the end of each full scan.

Function
REQ-016 On a cycle with Load=1, DataIn and DP_In SHALL be copied into shadow registers; the display SHALL use only the shadow registers, so a mid-frame DataIn change with Load=0 SHALL have no effect.
REQ-017 The divider SHALL count 0..DIV_COUNT-1 while En=1 and SHALL raise tick on the count DIV_COUNT-1, then wrap to 0.
REQ-018 On tick, the digit index SHALL advance by one and wrap from NUM_DIGITS-1 to 0; Frame_Done SHALL pulse for exactly the one cycle in which the index wraps.
REQ-019 A free-running PWM counter (PWM_BITS wide, +1 per Clk while En=1, natural wrap) SHALL gate the output: the digit is lit when Brightness is all ones or pwm_cnt < Brightness.
REQ-019a Brightness=0 SHALL therefore keep all digits dark.
REQ-020 Segment encoding (active-high, a=bit0) SHALL be:
- 0..7 = 3F, 06, 5B, 4F, 66, 6D, 7D, 07
- 8..F = 7F, 6F, 77, 7C, 39, 5E, 79, 71
REQ-021 With Blank_LZ=1, digit i>0 SHALL be blanked (segments g..a off) when shadow nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be blanked; the DP of a blanked digit SHALL still follow its DP_In shadow bit.
REQ-022 When lit, SSD_Select SHALL assert only bit [index]; when dark, SSD_Select SHALL assert no bits and SSD_Out SHALL be all segments off (polarity-adjusted).
REQ-023 SSD_Out and SSD_Select SHALL be registered, with exactly one Clk of latency from an index, PWM or shadow change to the pins.
REQ-024 While En=0, the divider, PWM counter and index SHALL be held at 0, outputs SHALL be dark, and Frame_Done SHALL be 0; shadow loads SHALL still occur on Load=1.
REQ-025 Polarity SHALL be applied only at the output registers: when COMMON_ANODE=1, the dark state is SSD_Out=FF and SSD_Select all ones.
REQ-026 Load coincident with tick SHALL take effect from the next digit slot without glitching the current slot's registered output for more than the one-cycle latency.

Reset
REQ-027 Rst_n=0 SHALL asynchronously clear the shadow registers, divider, PWM counter, index and Frame_Done.
REQ-028 During reset, SSD_Out and SSD_Select SHALL take the dark state.
REQ-029 A reset asserted mid-slot SHALL restart the scan at digit 0 with the divider at 0 after release.

Structure
REQ-030 Package ssd_pkg SHALL hold the 16-entry segment table constant, the SEG_OFF constant and the digit-index width helper.
REQ-031 A combinational sub-module ssd_hex_decoder (nibble -> 7 segments) SHALL be instantiated once, on the selected nibble.

Verification
REQ-032 Scan test: DIV_COUNT=4, NUM_DIGITS=4, COMMON_ANODE=0, Brightness=F, Load DataIn=0x12AB -> SSD_Select 0001/0010/0100/1000 every 4 cycles; SSD_Out 7C,77,5B,06; Frame_Done once per 16 cycles.
REQ-033 Blanking test: DataIn=0x0005, Blank_LZ=1, DP_In=0100 -> digit 0 shows 6D; digits 1 and 3 show 00; digit 2 shows 80.
REQ-034 PWM test: Brightness=4, PWM_BITS=4 -> SSD_Select non-zero for exactly 4 of every 16 cycles; Brightness=0 -> SSD_Select never non-zero.
REQ-035 Shadow test: Load 0x1111, then change DataIn to 0x2222 with Load=0 -> display stays 06 on all digits until the next Load pulse.
REQ-036 Reset/enable test: assert Rst_n=0 mid-slot with COMMON_ANODE=1 -> SSD_Out=FF and SSD_Select=F immediately; after release, the first lit digit is digit 0 after DIV_COUNT cycles; En=0 -> outputs dark and Frame_Done stays 0.
